// File: rtl/rv32i.sv
// rv32i: single-cycle RV32I subset core with built-in instruction ROM and data RAM
module rv32i_ctrl (
   input  logic [6:0] op_i,
   input  logic [2:0] f3_i,
   input  logic       f7b5_i,
   input  logic       zero_i,
   output logic       reg_write_o,
   output logic       mem_write_o,
   output logic       alu_src_o,
   output logic       pc_src_o,
   output logic [1:0] imm_src_o,
   output logic [1:0] result_src_o,
   output logic [2:0] alu_ctl_o
);
   logic r_type, i_type, alu_op, lw, sw, beq, jal;
   assign r_type = op_i == 7'b0110011;
   assign i_type = op_i == 7'b0010011;
   assign alu_op = (r_type | i_type) & (f3_i inside {3'b000, 3'b010, 3'b110, 3'b111});
   assign lw     = op_i == 7'b0000011 && f3_i == 3'b010;
   assign sw     = op_i == 7'b0100011 && f3_i == 3'b010;
   assign beq    = op_i == 7'b1100011 && f3_i == 3'b000;
   assign jal    = op_i == 7'b1101111;
   assign reg_write_o  = alu_op | lw | jal;
   assign mem_write_o  = sw;
   assign alu_src_o    = i_type | lw | sw;
   assign pc_src_o     = jal | (beq & zero_i);
   assign imm_src_o    = sw ? 2'd1 : beq ? 2'd2 : jal ? 2'd3 : 2'd0;
   assign result_src_o = lw ? 2'd1 : jal ? 2'd2 : 2'd0;
   // alu_ctl: 0 add, 1 sub, 2 and, 3 or, 5 slt
   assign alu_ctl_o = beq ? 3'd1 : !alu_op ? 3'd0 :
                      f3_i == 3'b111 ? 3'd2 : f3_i == 3'b110 ? 3'd3 :
                      f3_i == 3'b010 ? 3'd5 : (r_type & f7b5_i) ? 3'd1 : 3'd0;
endmodule

module rv32i_dp (
   input  logic        clk,
   input  logic        reset,
   input  logic        regWrite,
   input  logic        aluSrc,
   input  logic        memWrite,
   input  logic        pc_src_i,
   input  logic [1:0]  imm_src_i,
   input  logic [1:0]  result_src_i,
   input  logic [2:0]  alu_ctl_i,
   output logic [6:0]  op_o,
   output logic [2:0]  f3_o,
   output logic        f7b5_o,
   output logic        zero_o,
   output logic [31:0] pc_o,
   output logic [31:0] alu_o,
   output logic [31:0] wdata_o,
   output logic [31:0] regs_o [32]
);
   logic [31:0] instr, pc_q, pc_d, pc4, imm, rd1, rd2, src_b, alu, rdata, result;
   logic [31:0] rf_q [32];
   logic [31:0] ram_q [64];
   function automatic logic [31:0] rom(input logic [5:0] a);
      case (a)
         6'd0:    rom = 32'h00300413;
         6'd1:    rom = 32'h00100493;
         6'd2:    rom = 32'h01000913;
         6'd3:    rom = 32'h009462B3;
         6'd4:    rom = 32'h00947333;
         6'd5:    rom = 32'h009403B3;
         6'd6:    rom = 32'h40940E33;
         6'd7:    rom = 32'h40848EB3;
         6'd8:    rom = 32'h0000006F;
         default: rom = 32'h0;
      endcase
   endfunction
   assign instr  = rom(pc_q[7:2]);
   assign op_o   = instr[6:0];
   assign f3_o   = instr[14:12];
   assign f7b5_o = instr[30];
   assign imm = imm_src_i == 2'd0 ? {{20{instr[31]}}, instr[31:20]} :
                imm_src_i == 2'd1 ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                imm_src_i == 2'd2 ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                                    {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign rd1   = rf_q[instr[19:15]];
   assign rd2   = rf_q[instr[24:20]];
   assign src_b = aluSrc ? imm : rd2;
   assign alu = alu_ctl_i == 3'd1 ? rd1 - src_b :
                alu_ctl_i == 3'd2 ? rd1 & src_b :
                alu_ctl_i == 3'd3 ? rd1 | src_b :
                alu_ctl_i == 3'd5 ? {31'b0, $signed(rd1) < $signed(src_b)} : rd1 + src_b;
   assign zero_o = alu == 32'b0;
   assign rdata  = ram_q[alu[7:2]];
   assign pc4    = pc_q + 32'd4;
   assign result = result_src_i == 2'd1 ? rdata : result_src_i == 2'd2 ? pc4 : alu;
   assign pc_d   = reset ? 32'b0 : pc_src_i ? pc_q + imm : pc4;
   always_ff @(posedge clk) begin
      pc_q <= pc_d;
      if (reset) rf_q <= '{default: '0};
      else if (regWrite && instr[11:7] != 5'd0) rf_q[instr[11:7]] <= result;
   end
   // data RAM keeps its contents across reset
   always_ff @(posedge clk) begin
      if (memWrite && !reset) ram_q[alu[7:2]] <= rd2;
   end
   assign pc_o    = pc_q;
   assign alu_o   = alu;
   assign wdata_o = rd2;
   assign regs_o  = rf_q;
endmodule

module rv32i (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   output logic [31:0] aluResult,
   output logic [31:0] writeData,
   output logic        memWrite,
   output logic [31:0] reg0,  output logic [31:0] reg1,  output logic [31:0] reg2,  output logic [31:0] reg3,
   output logic [31:0] reg4,  output logic [31:0] reg5,  output logic [31:0] reg6,  output logic [31:0] reg7,
   output logic [31:0] reg8,  output logic [31:0] reg9,  output logic [31:0] reg10, output logic [31:0] reg11,
   output logic [31:0] reg12, output logic [31:0] reg13, output logic [31:0] reg14, output logic [31:0] reg15,
   output logic [31:0] reg16, output logic [31:0] reg17, output logic [31:0] reg18, output logic [31:0] reg19,
   output logic [31:0] reg20, output logic [31:0] reg21, output logic [31:0] reg22, output logic [31:0] reg23,
   output logic [31:0] reg24, output logic [31:0] reg25, output logic [31:0] reg26, output logic [31:0] reg27,
   output logic [31:0] reg28, output logic [31:0] reg29, output logic [31:0] reg30, output logic [31:0] reg31
);
   logic [6:0]  op;
   logic [2:0]  f3, alu_ctl;
   logic [1:0]  imm_src, result_src;
   logic        f7b5, zero, regWrite, aluSrc, pc_src;
   logic [31:0] regs [32];
   rv32i_ctrl ctl (
      .op_i(op), .f3_i(f3), .f7b5_i(f7b5), .zero_i(zero),
      .reg_write_o(regWrite), .mem_write_o(memWrite), .alu_src_o(aluSrc), .pc_src_o(pc_src),
      .imm_src_o(imm_src), .result_src_o(result_src), .alu_ctl_o(alu_ctl)
   );
   rv32i_dp dp (
      .clk(clk), .reset(reset), .regWrite(regWrite), .aluSrc(aluSrc), .memWrite(memWrite),
      .pc_src_i(pc_src), .imm_src_i(imm_src), .result_src_i(result_src), .alu_ctl_i(alu_ctl),
      .op_o(op), .f3_o(f3), .f7b5_o(f7b5), .zero_o(zero),
      .pc_o(pc), .alu_o(aluResult), .wdata_o(writeData), .regs_o(regs)
   );
   assign reg0  = regs[0];  assign reg1  = regs[1];  assign reg2  = regs[2];  assign reg3  = regs[3];
   assign reg4  = regs[4];  assign reg5  = regs[5];  assign reg6  = regs[6];  assign reg7  = regs[7];
   assign reg8  = regs[8];  assign reg9  = regs[9];  assign reg10 = regs[10]; assign reg11 = regs[11];
   assign reg12 = regs[12]; assign reg13 = regs[13]; assign reg14 = regs[14]; assign reg15 = regs[15];
   assign reg16 = regs[16]; assign reg17 = regs[17]; assign reg18 = regs[18]; assign reg19 = regs[19];
   assign reg20 = regs[20]; assign reg21 = regs[21]; assign reg22 = regs[22]; assign reg23 = regs[23];
   assign reg24 = regs[24]; assign reg25 = regs[25]; assign reg26 = regs[26]; assign reg27 = regs[27];
   assign reg28 = regs[28]; assign reg29 = regs[29]; assign reg30 = regs[30]; assign reg31 = regs[31];
endmodule

// File: tb/tb_rv32i.sv
// tb_rv32i: directed checks of the default program, resets, and a forced load/store/branch sequence
module tb_rv32i;
   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] pc, aluResult, writeData, fi;
   logic        memWrite;
   logic [31:0] r [32];
   int          n_vec = 0, n_err = 0;
   rv32i dut (
      .clk(clk), .reset(reset), .pc(pc), .aluResult(aluResult), .writeData(writeData), .memWrite(memWrite),
      .reg0(r[0]),   .reg1(r[1]),   .reg2(r[2]),   .reg3(r[3]),   .reg4(r[4]),   .reg5(r[5]),   .reg6(r[6]),   .reg7(r[7]),
      .reg8(r[8]),   .reg9(r[9]),   .reg10(r[10]), .reg11(r[11]), .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
      .reg16(r[16]), .reg17(r[17]), .reg18(r[18]), .reg19(r[19]), .reg20(r[20]), .reg21(r[21]), .reg22(r[22]), .reg23(r[23]),
      .reg24(r[24]), .reg25(r[25]), .reg26(r[26]), .reg27(r[27]), .reg28(r[28]), .reg29(r[29]), .reg30(r[30]), .reg31(r[31])
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic check_regs_zero(input string tag);
      for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), r[i], 32'h0);
   endtask
   task automatic edge_sample(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      fi = 32'h0;
      edge_sample(10);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", dut.dp.instr, 32'h00300413);
      check("rst_alu", aluResult, 32'h3);
      check("rst_wdata", writeData, 32'h0);
      check("rst_memwrite", {31'b0, memWrite}, 32'h0);
      check_regs_zero("rst");
      @(negedge clk) reset = 1'b0;
      edge_sample(5);
      check("setup_s0", r[8], 32'h3);
      check("setup_s1", r[9], 32'h1);
      check("setup_s2", r[18], 32'h10);
      check("setup_pc", pc, 32'h14);
      edge_sample(10);
      check("or_t0", r[5], 32'h3);
      check("and_t1", r[6], 32'h1);
      check("add_t2", r[7], 32'h4);
      check("sub_t3", r[28], 32'h2);
      check("sub_neg_t4", r[29], 32'hFFFFFFFE);
      check("halt_pc", pc, 32'h20);
      edge_sample(7);
      check("halt_pc_hold", pc, 32'h20);
      check("halt_memwrite", {31'b0, memWrite}, 32'h0);
      check("halt_t4_hold", r[29], 32'hFFFFFFFE);
      check("halt_ra_untouched", r[1], 32'h0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      edge_sample(4);
      check("mid_pc_before", pc, 32'h10);
      check("mid_s0_before", r[8], 32'h3);
      @(negedge clk) reset = 1'b1;
      edge_sample(1);
      check("mid_pc_after", pc, 32'h0);
      check_regs_zero("mid");
      @(negedge clk) reset = 1'b0;
      edge_sample(5);
      check("mid_s0_again", r[8], 32'h3);
      check("mid_pc_again", pc, 32'h14);
      @(negedge clk) reset = 1'b1;
      fi = 32'h00700293;
      force dut.dp.instr = fi;
      @(negedge clk) reset = 1'b0;
      #1 check("addi_alu", aluResult, 32'h7);
      edge_sample(1);
      check("addi_x5", r[5], 32'h7);
      check("addi_pc", pc, 32'h4);
      @(negedge clk) fi = 32'h04502023;
      #1;
      check("sw_memwrite", {31'b0, memWrite}, 32'h1);
      check("sw_addr", aluResult, 32'h40);
      check("sw_data", writeData, 32'h7);
      edge_sample(1);
      @(negedge clk) fi = 32'h04002303;
      #1;
      check("lw_addr", aluResult, 32'h40);
      check("lw_memwrite", {31'b0, memWrite}, 32'h0);
      edge_sample(1);
      check("lw_x6", r[6], 32'h7);
      @(negedge clk) fi = 32'h00500013;
      edge_sample(1);
      check("addi_x0", r[0], 32'h0);
      check("addi_x0_pc", pc, 32'h10);
      @(negedge clk) fi = 32'h00628863;
      edge_sample(1);
      check("beq_taken_pc", pc, 32'h20);
      @(negedge clk) fi = 32'h00028863;
      edge_sample(1);
      check("beq_not_taken_pc", pc, 32'h24);
      @(negedge clk) fi = 32'h0082A393;
      edge_sample(1);
      check("slti_x7", r[7], 32'h1);
      @(negedge clk) fi = 32'hFFFFFFFF;
      #1 check("nop_memwrite", {31'b0, memWrite}, 32'h0);
      edge_sample(1);
      check("nop_pc", pc, 32'h2C);
      check("nop_x7_hold", r[7], 32'h1);
      check("nop_x31_hold", r[31], 32'h0);
      release dut.dp.instr;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
